// File: rtl/bitserial_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
package bitserial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bitserial_add_ctrl_fa.sv
// Combinational 1-bit full adder; the single arithmetic cell of the datapath.
module bitserial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bitserial_add_ctrl.sv
// WIDTH-bit add/subtract computed LSB first through one shared full-adder cell,
// with valid/ready handshakes on operand and result sides.
module bitserial_add_ctrl
  import bitserial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q;
  logic             ovf_q;
  logic             s_bit;
  logic             c_bit;

  bitserial_add_ctrl_fa u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (s_bit),
    .cout(c_bit)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 stays legal.
  assign sum_d = WIDTH'({s_bit, sum_q} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= (in_sub == OP_SUB) ? ~in_b : in_b;
            carry_q <= (in_sub == OP_SUB);
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= c_bit;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            cout_q  <= c_bit;
            ovf_q   <= c_bit ^ carry_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
